// File: rtl/dual_mul_driver.sv
// rtl/dual_mul_driver.sv - dual-multiplier initiator: launch one operation, capture two results, compare, count errors
module dual_mul_driver #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  output logic             busy,
  output logic [31:0]      op1,
  output logic [31:0]      op2,
  output logic             mul_ready,
  input  logic             mul_done,
  input  logic [31:0]      mul_res,
  output logic [31:0]      res_a,
  output logic [31:0]      res_b,
  output logic             valid,
  output logic             match,
  output logic             timeout,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAP2, S_DRAIN} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [15:0]        timer_q, timer_d;
  logic               busy_q, busy_d;
  logic [31:0]        op1_q, op1_d;
  logic [31:0]        op2_q, op2_d;
  logic               ready_q, ready_d;
  logic [31:0]        res_a_q, res_a_d;
  logic [31:0]        res_b_q, res_b_d;
  logic               valid_q, valid_d;
  logic               match_q, match_d;
  logic               tmo_q, tmo_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               err_inc;
  logic               cap_match;

  // NaNs compare equal regardless of payload/sign, and +0 equals -0
  function automatic logic fp_eq(input logic [31:0] x, input logic [31:0] y);
    logic x_nan, y_nan;
    x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    return (x == y) || (x_nan && y_nan) || ((x[30:0] == 31'd0) && (y[30:0] == 31'd0));
  endfunction

  // A missing second done cycle counts as a mismatch
  assign cap_match = mul_done && fp_eq(res_a_q, mul_res);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    ready_d = 1'b0;
    res_a_d = res_a_q;
    res_b_d = res_b_q;
    valid_d = 1'b0;
    match_d = match_q;
    tmo_d   = tmo_q;
    err_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op1_d   = a;
          op2_d   = b;
          ready_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) begin
          res_a_d = mul_res;
          state_d = S_CAP2;
        end else if (timer_q == TMO_LAST) begin
          valid_d = 1'b1;
          tmo_d   = 1'b1;
          match_d = 1'b0;
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_CAP2: begin
        res_b_d = mul_res;
        valid_d = 1'b1;
        match_d = cap_match;
        tmo_d   = 1'b0;
        err_inc = !cap_match;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!mul_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    err_d  = (err_inc && (err_q != '1)) ? err_q + CNT_W'(1) : err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      busy_q  <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      ready_q <= 1'b0;
      res_a_q <= '0;
      res_b_q <= '0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      ready_q <= ready_d;
      res_a_q <= res_a_d;
      res_b_q <= res_b_d;
      valid_q <= valid_d;
      match_q <= match_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign busy      = busy_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign mul_ready = ready_q;
  assign res_a     = res_a_q;
  assign res_b     = res_b_q;
  assign valid     = valid_q;
  assign match     = match_q;
  assign timeout   = tmo_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_dual_mul_driver.sv
// tb/tb_dual_mul_driver.sv - table-driven and randomized checks of dual_mul_driver against a behavioural model
module tb_dual_mul_driver;

  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      a, b;
  logic             busy;
  logic [31:0]      op1, op2;
  logic             mul_ready;
  logic             mul_done;
  logic [31:0]      mul_res;
  logic [31:0]      res_a, res_b;
  logic             valid, match, timeout;
  logic [CNT_W-1:0] err_count;

  dual_mul_driver #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .busy(busy),
    .op1(op1), .op2(op2), .mul_ready(mul_ready), .mul_done(mul_done),
    .mul_res(mul_res), .res_a(res_a), .res_b(res_b), .valid(valid),
    .match(match), .timeout(timeout), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_err = 0;
  int cyc = 0, vcount = 0, rcount = 0, v_cyc = 0, r_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcount <= vcount + 1;
      v_cyc  <= cyc;
    end
    if (mul_ready) begin
      rcount <= rcount + 1;
      r_cyc  <= cyc;
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          dly;
    logic [31:0] r1;
    logic [31:0] r2;
    int          ndone;
    bit          exp_match;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit ref_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic bit ref_eq(input logic [31:0] x, input logic [31:0] y);
    if (ref_is_nan(x) || ref_is_nan(y)) return ref_is_nan(x) && ref_is_nan(y);
    if (((x & 32'h7FFF_FFFF) == 32'd0) && ((y & 32'h7FFF_FFFF) == 32'd0)) return 1'b1;
    return x == y;
  endfunction

  task automatic model_err();
    if (exp_err < int'(CNT_MAX)) exp_err++;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " busy"}, 64'(busy), 64'd0);
    check({name, " op1"}, 64'(op1), 64'd0);
    check({name, " op2"}, 64'(op2), 64'd0);
    check({name, " mul_ready"}, 64'(mul_ready), 64'd0);
    check({name, " res_a"}, 64'(res_a), 64'd0);
    check({name, " res_b"}, 64'(res_b), 64'd0);
    check({name, " valid/match/timeout"}, 64'({valid, match, timeout}), 64'd0);
    check({name, " err_count"}, 64'(err_count), 64'd0);
  endtask

  task automatic wait_valid(input int v0, input string name);
    int n;
    n = 0;
    while (vcount == v0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, " valid seen"}, 64'(vcount != v0), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, " back to idle"}, 64'(busy), 64'd0);
  endtask

  // One full operation; dly >= 1 is the number of cycles after the launch before done rises
  task automatic run_op(input string name, input vec_t v);
    int v0, rc0;
    v0  = vcount;
    rc0 = rcount;
    @(negedge clk);
    start = 1'b1; a = v.a; b = v.b;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    check({name, " ready high"}, 64'(mul_ready), 64'd1);
    check({name, " busy"}, 64'(busy), 64'd1);
    check({name, " ops"}, {op1, op2}, {v.a, v.b});
    @(negedge clk);
    check({name, " ready pulse width"}, 64'(mul_ready), 64'd0);
    repeat (v.dly - 1) @(negedge clk);
    mul_done = 1'b1; mul_res = v.r1;
    @(negedge clk);
    mul_done = (v.ndone == 2); mul_res = v.r2;
    @(negedge clk);
    mul_done = 1'b0; mul_res = $urandom;
    wait_valid(v0, name);
    check({name, " latency"}, 64'(v_cyc - r_cyc), 64'(v.dly + 2));
    check({name, " match"}, 64'(match), 64'(v.exp_match));
    check({name, " timeout"}, 64'(timeout), 64'd0);
    check({name, " results"}, {res_a, res_b}, {v.r1, v.r2});
    if (!v.exp_match) model_err();
    check({name, " err_count"}, 64'(err_count), 64'(exp_err));
    wait_idle(name);
    check({name, " one valid one ready"}, 64'({vcount - v0, rcount - rc0}), {32'd1, 32'd1});
  endtask

  vec_t vecs[8];

  initial begin
    vec_t v;
    logic [31:0] tmp;
    int v0, rc0, extra;
    logic [31:0] acc_a, acc_b;
    bit stable_ok;

    vecs[0] = '{32'h40400000, 32'h40000000, 5,  32'h40C00000, 32'h40C00000, 2, 1'b1};
    vecs[1] = '{32'h40400000, 32'h40000000, 1,  32'h40C00000, 32'h40C00001, 2, 1'b0};
    vecs[2] = '{32'h3F800000, 32'h7FC00000, 2,  32'h7FC00000, 32'h7FC00123, 2, 1'b1};
    vecs[3] = '{32'h00000000, 32'h80000000, 1,  32'h00000000, 32'h80000000, 2, 1'b1};
    vecs[4] = '{32'h7F800000, 32'h3F800000, 2,  32'h7F800000, 32'h7FC00000, 2, 1'b0};
    vecs[5] = '{32'hFFC00000, 32'h7F800001, 3,  32'hFFC00000, 32'h7F800001, 2, 1'b1};
    vecs[6] = '{32'h40C00000, 32'h40C00000, 3,  32'h40C00000, 32'h40C00000, 1, 1'b0};
    vecs[7] = '{32'h12345678, 32'h9ABCDEF0, 64, 32'h3F800000, 32'h3F800000, 2, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; mul_done = 1'b0; mul_res = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Timeout: done never arrives, then a late done is ignored
    v0 = vcount; rc0 = rcount;
    @(negedge clk);
    start = 1'b1; a = 32'h11111111; b = 32'h22222222;
    @(negedge clk);
    start = 1'b0;
    check("tmo ready", 64'(mul_ready), 64'd1);
    wait_valid(v0, "tmo");
    check("tmo latency", 64'(v_cyc - r_cyc), 64'(TIMEOUT + 1));
    check("tmo flags", 64'({timeout, match}), 64'b10);
    model_err();
    check("tmo err_count", 64'(err_count), 64'(exp_err));
    @(negedge clk);
    check("tmo busy after", 64'(busy), 64'd0);
    mul_done = 1'b1; mul_res = 32'h40C00000;
    @(negedge clk);
    mul_res = 32'h40C00001;
    @(negedge clk);
    mul_done = 1'b0;
    repeat (3) @(negedge clk);
    check("late done ignored", 64'({vcount - v0, rcount - rc0}), {32'd1, 32'd1});
    check("late done busy", 64'(busy), 64'd0);
    check("late done err_count", 64'(err_count), 64'(exp_err));

    // start held high through an operation while a/b toggle
    v0 = vcount; rc0 = rcount; stable_ok = 1'b1;
    acc_a = $urandom; acc_b = $urandom;
    @(negedge clk);
    start = 1'b1; a = acc_a; b = acc_b;
    @(negedge clk);
    check("hold ready", 64'(mul_ready), 64'd1);
    for (int step = 1; step < 100; step++) begin
      @(negedge clk);
      if (!busy) begin
        start = 1'b0;
        break;
      end
      if (op1 !== acc_a || op2 !== acc_b) stable_ok = 1'b0;
      a = $urandom; b = $urandom;
      mul_done = (step == 2 || step == 3);
      mul_res = 32'h40490FDB;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("hold ops stable", 64'(stable_ok), 64'd1);
    check("hold single launch", 64'({vcount - v0, rcount - rc0}), {32'd1, 32'd1});
    check("hold match", 64'(match), 64'd1);

    // Randomized operations against the reference comparison
    for (int i = 0; i < 30; i++) begin
      tmp = $urandom;
      v.a = $urandom; v.b = $urandom; v.dly = $urandom_range(1, 20); v.ndone = 2;
      v.r1 = $urandom;
      case ($urandom_range(0, 3))
        0: v.r2 = v.r1;
        1: begin
          v.r1 = {v.r1[31], 8'hFF, v.r1[22:0] | 23'h1};
          v.r2 = {tmp[31], 8'hFF, tmp[22:0] | 23'h1};
        end
        2: begin
          v.r1 = {v.r1[31], 31'd0};
          v.r2 = {tmp[31], 31'd0};
        end
        default: v.r2 = tmp;
      endcase
      v.exp_match = ref_eq(v.r1, v.r2);
      run_op($sformatf("rnd%0d", i), v);
    end

    // Saturation of the error counter
    extra = 0;
    v = '{32'h40400000, 32'h40000000, 1, 32'h40C00000, 32'h40C00001, 2, 1'b0};
    while (extra < 3) begin
      run_op("sat", v);
      if (exp_err == int'(CNT_MAX)) extra++;
    end
    check("sat final", 64'(err_count), 64'(CNT_MAX));

    // Asynchronous reset while waiting
    @(negedge clk);
    start = 1'b1; a = 32'h40400000; b = 32'h40000000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rst_wait busy before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;

    // Asynchronous reset in CAP2, with done still high afterwards
    v0 = vcount; rc0 = rcount;
    @(negedge clk);
    start = 1'b1; a = 32'h40400000; b = 32'h40000000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    mul_done = 1'b1; mul_res = 32'h40C00000;
    @(negedge clk);
    check("rst_cap2 res_a before", 64'(res_a), 64'h40C00000);
    mul_res = 32'h40C00001;
    #2 rst = 1'b1;
    #1 check_all_zero("rst_cap2");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mul_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cap2 late done", 64'({vcount - v0, rcount - rc0}), {32'd0, 32'd1});
    check("rst_cap2 idle", 64'({busy, err_count}), 64'd0);

    run_op("after_reset", vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=expired required=finished");
    $fatal(1, "watchdog");
  end

endmodule
